// File: rtl/imm_packer.sv
// imm_packer: packs a 32-bit immediate into RISC-V instruction bits [31:7]
// for the I/S/U/J formats. It is the inverse of the Extend_unit decoder.
// There is one output register stage with valid/ready on both sides. Each
// word on the output carries the word-aligned address it should be written
// to. Two saturating counters track emitted words and range errors.
module imm_packer #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                CNT_W     = 16,
    parameter bit                DROP_ERR  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [24:0]       in_base,
    input  logic [1:0]        in_immsrc,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [24:0]       out_inst,
    output logic              out_err,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]  enc_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [1:0] SRC_I = 2'b00;
    localparam logic [1:0] SRC_S = 2'b01;
    localparam logic [1:0] SRC_U = 2'b10;

    // Overwrite only the immediate fields of the base word. Bit k of the
    // instruction lives at index k-7 of the 25-bit word.
    function automatic logic [24:0] pack_imm(input logic [24:0] base,
                                             input logic [1:0]  src,
                                             input logic [31:0] imm);
        logic [24:0] w;
        w = base;
        case (src)
            SRC_I: w[24:13] = imm[11:0];
            SRC_S: begin
                w[24:18] = imm[11:5];
                w[4:0]   = imm[4:0];
            end
            SRC_U: w[24:5] = imm[31:12];
            default: begin
                w[24]    = imm[20];
                w[23:14] = imm[10:1];
                w[13]    = imm[11];
                w[12:5]  = imm[19:12];
            end
        endcase
        return w;
    endfunction

    // Detect immediates that the selected format cannot represent exactly.
    function automatic logic range_err(input logic [1:0]  src,
                                       input logic [31:0] imm);
        logic e;
        case (src)
            SRC_I, SRC_S: e = !((imm[31:11] == '0) || (imm[31:11] == '1));
            SRC_U:        e = |imm[11:0];
            default:      e = !((imm[31:20] == '0) || (imm[31:20] == '1))
                              || imm[0];
        endcase
        return e;
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic              vld_p1;
    logic [24:0]       inst_p1;
    logic              err_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [CNT_W-1:0]  enc_cnt;
    logic [CNT_W-1:0]  err_cnt;

    logic [24:0] inst_p0;
    logic        err_p0;
    logic        acc;
    logic        ohs;
    logic        keep;

    // Stage 0: combinational pack and range check of the incoming request
    assign inst_p0  = pack_imm(in_base, in_immsrc, in_imm);
    assign err_p0   = range_err(in_immsrc, in_imm);
    assign in_ready = !vld_p1 || out_ready;
    assign acc      = in_valid && in_ready;
    assign ohs      = vld_p1 && out_ready;
    // When dropping is enabled, an erroneous word is accepted but never shown
    assign keep     = !(DROP_ERR && err_p0);

    // Stage 1: output register; a new word replaces one being handed off
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            inst_p1 <= '0;
            err_p1  <= 1'b0;
        end else if (acc && keep) begin
            vld_p1  <= 1'b1;
            inst_p1 <= inst_p0;
            err_p1  <= err_p0;
        end else if (acc || ohs) begin
            // An accept implies the register is empty or being drained,
            // so a dropped word leaves the output empty.
            vld_p1  <= 1'b0;
        end
    end

    // Address of the word on the output plus the running counters
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            addr_p1 <= BASE_ADDR;
            enc_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (ohs) begin
                addr_p1 <= addr_p1 + ADDR_W'(4);
                enc_cnt <= sat_inc(enc_cnt);
            end
            if (acc && err_p0) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_inst  = inst_p1;
    assign out_err   = err_p1;
    assign out_addr  = addr_p1;
    assign enc_count = enc_cnt;
    assign err_count = err_cnt;

endmodule

// File: tb/tb_imm_packer.sv
// tb_imm_packer: bench for imm_packer. Instance a uses the default
// parameters. Instance b uses DROP_ERR=1, a 5-bit wrapping address based
// at 24, and 3-bit counters.
module tb_imm_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance a
    logic        rst, clr, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [24:0] in_base, out_inst;
    logic [1:0]  in_immsrc;
    logic [31:0] in_imm, out_addr;
    logic [15:0] enc_count, err_count;

    // instance b
    logic        b_rst, b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [24:0] b_in_base, b_out_inst;
    logic [1:0]  b_in_immsrc;
    logic [31:0] b_in_imm;
    logic [4:0]  b_out_addr;
    logic [2:0]  b_enc_count, b_err_count;

    imm_packer #(.ADDR_W(32), .BASE_ADDR(32'd0), .CNT_W(16), .DROP_ERR(1'b0)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_base(in_base), .in_immsrc(in_immsrc), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .out_addr(out_addr), .enc_count(enc_count), .err_count(err_count));

    imm_packer #(.ADDR_W(5), .BASE_ADDR(5'd24), .CNT_W(3), .DROP_ERR(1'b1)) dut_b (
        .clk(clk), .rst(b_rst), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_base(b_in_base), .in_immsrc(b_in_immsrc), .in_imm(b_in_imm),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inst(b_out_inst),
        .out_err(b_out_err), .out_addr(b_out_addr), .enc_count(b_enc_count), .err_count(b_err_count));

    typedef struct {
        logic [24:0] base;
        logic [1:0]  src;
        logic [31:0] imm;
        logic [24:0] exp_inst;
        logic        exp_err;
    } req_t;

    typedef struct {
        logic [24:0] inst;
        logic        err;
        logic [1:0]  src;
        logic [31:0] imm;
    } sb_t;

    req_t req_q[$];
    sb_t  sb_q[$];
    req_t tbl[12];

    int checks = 0;
    int errors = 0;

    logic [31:0] m_addr;
    int          m_enc, m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference packer: build the full 32-bit instruction, then slice [31:7].
    function automatic logic [24:0] mdl_pack(input logic [24:0] base, input logic [1:0] src,
                                             input logic [31:0] imm);
        logic [31:0] ins;
        ins = {base, 7'b0};
        case (src)
            2'd0: ins[31:20] = imm[11:0];
            2'd1: begin ins[31:25] = imm[11:5]; ins[11:7] = imm[4:0]; end
            2'd2: ins[31:12] = imm[31:12];
            default: begin
                ins[31] = imm[20]; ins[30:21] = imm[10:1];
                ins[20] = imm[11]; ins[19:12] = imm[19:12];
            end
        endcase
        return ins[31:7];
    endfunction

    // Reference range check expressed as signed numeric bounds.
    function automatic logic mdl_err(input logic [1:0] src, input logic [31:0] imm);
        logic signed [31:0] s;
        s = imm;
        case (src)
            2'd0, 2'd1: return (s < -2048) || (s > 2047);
            2'd2:       return imm[11:0] != 12'd0;
            default:    return (s < -(32'sd1 <<< 20)) || (s > (32'sd1 <<< 20) - 1) || imm[0];
        endcase
    endfunction

    // Extend_unit equivalent: recover the immediate from packed bits.
    function automatic logic [31:0] extend(input logic [24:0] w, input logic [1:0] src);
        logic [31:0] ins;
        ins = {w, 7'b0};
        case (src)
            2'd0: return {{20{ins[31]}}, ins[31:20]};
            2'd1: return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            2'd2: return {ins[31:12], 12'b0};
            default: return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        endcase
    endfunction

    function automatic req_t rand_legal();
        req_t        r;
        logic [31:0] v;
        v      = $urandom;
        r.base = 25'($urandom);
        r.src  = 2'($urandom_range(0, 3));
        case (r.src)
            2'd0, 2'd1: r.imm = {{20{v[11]}}, v[11:0]};
            2'd2:       r.imm = {v[31:12], 12'b0};
            default:    r.imm = {{11{v[20]}}, v[20:1], 1'b0};
        endcase
        r.exp_inst = mdl_pack(r.base, r.src, r.imm);
        r.exp_err  = mdl_err(r.src, r.imm);
        return r;
    endfunction

    task automatic edge_a();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive queued requests into instance a and score the outputs.
    // rdy_mode 0: out_ready high; 1: toggles 1010...; 2: random with input gaps.
    task automatic run(input int rdy_mode, input int clr_at);
        int          cyc, budget;
        bit          stall_prev, clr_prev, acc_prev;
        logic [24:0] h_inst;
        logic        h_err, acc, ohs;
        logic [31:0] h_addr;
        req_t        r;
        sb_t         e;
        cyc = 0; stall_prev = 0; clr_prev = 0; acc_prev = 0;
        budget = 20 + 4 * (req_q.size() + sb_q.size());
        while ((req_q.size() > 0 || sb_q.size() > 0) && cyc < budget) begin
            if (req_q.size() > 0 && (rdy_mode != 2 || $urandom_range(0, 3) != 0)) begin
                in_valid  = 1'b1;
                in_base   = req_q[0].base;
                in_immsrc = req_q[0].src;
                in_imm    = req_q[0].imm;
            end else begin
                in_valid = 1'b0;
            end
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            clr = (cyc == clr_at);
            #1;
            if (acc_prev) chk("latency_vld", out_valid, 1);
            if (stall_prev) begin
                chk("stall_vld", out_valid, 1);
                chk("stall_inst", out_inst, h_inst);
                chk("stall_err", out_err, h_err);
                if (!clr_prev) chk("stall_addr", out_addr, h_addr);
            end
            chk("in_ready", in_ready, !out_valid || out_ready);
            acc = in_valid && in_ready;
            ohs = out_valid && out_ready;
            stall_prev = out_valid && !out_ready;
            h_inst = out_inst; h_err = out_err; h_addr = out_addr;
            if (ohs) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty: got word %0h, want none", out_inst);
                end else begin
                    e = sb_q.pop_front();
                    chk("inst", out_inst, e.inst);
                    chk("err", out_err, e.err);
                    chk("addr", out_addr, m_addr);
                    if (!e.err) chk("roundtrip", extend(out_inst, e.src), e.imm);
                end
            end
            if (acc) begin
                r = req_q.pop_front();
                sb_q.push_back('{r.exp_inst, r.exp_err, r.src, r.imm});
            end
            if (clr) begin
                m_addr = 32'd0; m_enc = 0; m_err = 0;
            end else begin
                if (ohs) begin
                    m_addr += 32'd4;
                    if (m_enc < 65535) m_enc++;
                end
                if (acc && r.exp_err && m_err < 65535) m_err++;
            end
            acc_prev = acc;
            clr_prev = clr;
            edge_a();
            cyc++;
            if (clr_prev) begin
                chk("clr_addr", out_addr, 0);
                chk("clr_enc", enc_count, 0);
                chk("clr_errc", err_count, 0);
            end
        end
        if (req_q.size() > 0 || sb_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL timeout: got %0d pending, want 0", req_q.size() + sb_q.size());
            req_q.delete(); sb_q.delete();
        end
        in_valid = 1'b0;
        clr      = 1'b0;
        #1;
        chk("enc_count", enc_count, m_enc);
        chk("err_count", err_count, m_err);
    endtask

    task automatic b_req(input logic v, input logic [1:0] src, input logic [31:0] imm);
        b_in_valid  = v;
        b_in_base   = 25'd0;
        b_in_immsrc = src;
        b_in_imm    = imm;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_base = '0; in_immsrc = '0; in_imm = '0;
        b_rst = 1'b1; b_clr = 1'b0; b_out_ready = 1'b1;
        b_req(1'b0, 2'd0, 32'd0);
        m_addr = 32'd0; m_enc = 0; m_err = 0;

        tbl[0]  = '{25'h0000000, 2'd0, 32'hFFFF_FFFF, 25'h1FFE000, 1'b0};
        tbl[1]  = '{25'h0000000, 2'd1, 32'h0000_0800, 25'h1000000, 1'b1};
        tbl[2]  = '{25'h0000000, 2'd3, 32'h0000_0802, 25'h0006000, 1'b0};
        tbl[3]  = '{25'h0000000, 2'd3, 32'h0000_0003, 25'h0004000, 1'b1};
        tbl[4]  = '{25'h0000000, 2'd2, 32'h1234_5000, 25'h02468A0, 1'b0};
        tbl[5]  = '{25'h0000000, 2'd2, 32'h1234_5001, 25'h02468A0, 1'b1};
        tbl[6]  = '{25'h1FFFFFF, 2'd0, 32'h0000_0000, 25'h0001FFF, 1'b0};
        tbl[7]  = '{25'h1FFFFFF, 2'd1, 32'hFFFF_F800, 25'h103FFE0, 1'b0};
        tbl[8]  = '{25'h0000000, 2'd0, 32'h0000_07FF, 25'h0FFE000, 1'b0};
        tbl[9]  = '{25'h0000000, 2'd0, 32'hFFFF_F7FF, 25'h0FFE000, 1'b1};
        tbl[10] = '{25'h0000000, 2'd3, 32'hFFF0_0000, 25'h1000000, 1'b0};
        tbl[11] = '{25'h0000000, 2'd3, 32'h0010_0000, 25'h1000000, 1'b1};

        edge_a(); edge_a();
        rst = 1'b0; b_rst = 1'b0;
        #1;
        chk("rst_vld", out_valid, 0);
        chk("rst_inst", out_inst, 0);
        chk("rst_err", out_err, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_enc", enc_count, 0);
        chk("rst_errc", err_count, 0);
        chk("rst_rdy", in_ready, 1);
        chk("b_rst_addr", b_out_addr, 24);
        chk("b_rst_vld", b_out_valid, 0);

        // Directed table at full throughput
        foreach (tbl[i]) req_q.push_back(tbl[i]);
        run(0, -1);

        // Eight-word stream with out_ready toggling, addresses from zero
        clr = 1'b1; edge_a(); clr = 1'b0;
        m_addr = 32'd0; m_enc = 0; m_err = 0;
        #1;
        chk("clr_addr0", out_addr, 0);
        chk("clr_enc0", enc_count, 0);
        for (int i = 0; i < 8; i++) req_q.push_back(rand_legal());
        run(1, -1);
        chk("stream_addr_end", out_addr, 32);

        // Random legal round trip with a clear in the middle
        for (int i = 0; i < 1000; i++) req_q.push_back(rand_legal());
        run(2, 500);

        // Reset with a stalled word pending (rst together with clr)
        out_ready = 1'b0; in_valid = 1'b1; in_base = '0; in_immsrc = 2'd2; in_imm = 32'h1234_5000;
        edge_a();
        in_valid = 1'b0;
        #1;
        chk("pre_rst_vld", out_valid, 1);
        rst = 1'b1; clr = 1'b1;
        edge_a();
        rst = 1'b0; clr = 1'b0;
        #1;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_inst", out_inst, 0);
        chk("mid_rst_addr", out_addr, 0);
        chk("mid_rst_enc", enc_count, 0);
        chk("mid_rst_errc", err_count, 0);

        // clr leaves a stalled word untouched, and wins over an increment
        in_valid = 1'b1; in_immsrc = 2'd0; in_imm = 32'h0000_1007;
        edge_a();
        in_valid = 1'b0;
        #1;
        chk("clr_pre_errc", err_count, 1);
        chk("clr_pre_err", out_err, 1);
        clr = 1'b1;
        edge_a();
        #1;
        chk("clr_keep_vld", out_valid, 1);
        chk("clr_keep_inst", out_inst, 25'h000E000);
        chk("clr_errc", err_count, 0);
        out_ready = 1'b1;
        edge_a();
        clr = 1'b0;
        #1;
        chk("clr_win_enc", enc_count, 0);
        chk("clr_win_addr", out_addr, 0);
        chk("clr_hs_vld", out_valid, 0);

        // Instance b: dropped errors, address wrap, counter saturation
        b_req(1'b1, 2'd1, 32'd2048);
        edge_a(); b_req(1'b0, 2'd0, 32'd0); #1;
        chk("b_drop_vld", b_out_valid, 0);
        chk("b_drop_errc", b_err_count, 1);
        chk("b_drop_enc", b_enc_count, 0);
        b_req(1'b1, 2'd0, 32'd5);
        edge_a(); b_req(1'b0, 2'd0, 32'd0); #1;
        chk("b_vld", b_out_valid, 1);
        chk("b_inst", b_out_inst, 25'h000A000);
        chk("b_addr0", b_out_addr, 24);
        edge_a(); #1;
        chk("b_hs_vld", b_out_valid, 0);
        chk("b_addr1", b_out_addr, 28);
        b_req(1'b1, 2'd0, 32'd1);
        edge_a(); #1;
        chk("b_addr2", b_out_addr, 28);
        b_req(1'b1, 2'd0, 32'd2);
        edge_a(); b_req(1'b0, 2'd0, 32'd0); #1;
        chk("b_wrap_vld", b_out_valid, 1);
        chk("b_wrap_addr", b_out_addr, 0);
        chk("b_wrap_inst", b_out_inst, 25'h0004000);
        edge_a(); #1;
        chk("b_enc3", b_enc_count, 3);
        for (int i = 0; i < 8; i++) begin
            b_req(1'b1, 2'd2, 32'd1);
            edge_a();
        end
        b_req(1'b0, 2'd0, 32'd0); #1;
        chk("b_errc_sat", b_err_count, 7);
        chk("b_err_vld", b_out_valid, 0);
        for (int i = 0; i < 5; i++) begin
            b_req(1'b1, 2'd0, 32'(i));
            edge_a();
        end
        b_req(1'b0, 2'd0, 32'd0);
        edge_a(); #1;
        chk("b_enc_sat", b_enc_count, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
